ex_div_ctrl: RTL and testbench

//  Iterative divider sequencer for the EX stage. Shares one radix-2 restoring

---
 rtl/ex_div_ctrl_pkg.sv | 20 ++
 rtl/ex_div_ctrl_div_step.sv | 20 ++
 rtl/ex_div_ctrl.sv | 123 ++++++++++++
 tb/tb_ex_div_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ex_div_ctrl_pkg.sv
// Shared definitions for the EX-stage iterative divider: state encodings,
// handshake levels and the double-width result bus.
package ex_div_ctrl_pkg;

  localparam int DIV_WIDTH      = 32;
  localparam int DOUBLE_REG_BUS = 2 * DIV_WIDTH;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/ex_div_ctrl_div_step.sv
// One combinational radix-2 restoring division step: trial-subtract the
// divisor from the shifted partial remainder and keep it only if it did not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   partial_rem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             quo_bit
);

  logic [WIDTH:0] diff;

  // The partial remainder is always below twice the divisor, so the MSB of the
  // WIDTH+1-bit difference is exactly the borrow.
  assign diff     = partial_rem - {1'b0, divisor};
  assign quo_bit  = ~diff[WIDTH];
  assign next_rem = quo_bit ? diff[WIDTH-1:0] : partial_rem[WIDTH-1:0];

endmodule

// File: rtl/ex_div_ctrl.sv
// EX-stage divide sequencer: runs the shared restoring step over WIDTH cycles
// for DIV/DIVU and stalls the pipeline until {remainder, quotient} is ready.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             neg_quo;
  logic             neg_rem;

  logic [WIDTH-1:0] op1_mag;
  logic [WIDTH-1:0] op2_mag;
  logic [WIDTH-1:0] next_rem;
  logic             quo_bit;
  logic [WIDTH-1:0] last_quo;
  logic [WIDTH-1:0] fixed_quo;
  logic [WIDTH-1:0] fixed_rem;

  assign op1_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign op2_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // The dividend register doubles as the quotient: its MSB feeds the step and
  // the new quotient bit enters at the bottom.
  div_step #(.WIDTH(WIDTH)) u_div_step (
    .partial_rem (({rem, quo[WIDTH-1]})),
    .divisor     (divisor),
    .next_rem    (next_rem),
    .quo_bit     (quo_bit)
  );

  assign last_quo  = {quo[WIDTH-2:0], quo_bit};
  assign fixed_quo = neg_quo ? -last_quo : last_quo;
  assign fixed_rem = neg_rem ? -next_rem : next_rem;

  assign stallreq_o = start_i & ~annul_i & ~ready_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_o  <= DIV_RESULT_NOT_READY;
          result_o <= '0;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DIV_BY_ZERO;
            end else begin
              state   <= DIV_ON;
              cnt     <= '0;
              rem     <= '0;
              quo     <= op1_mag;
              divisor <= op2_mag;
              neg_quo <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_rem <= signed_div_i & opdata1_i[WIDTH-1];
            end
          end
        end
        DIV_BY_ZERO: begin
          if (annul_i) begin
            state <= DIV_FREE;
          end else begin
            state    <= DIV_END;
            ready_o  <= DIV_RESULT_READY;
            result_o <= '0;
          end
        end
        DIV_ON: begin
          if (annul_i) begin
            state <= DIV_FREE;
            cnt   <= '0;
          end else begin
            rem <= next_rem;
            quo <= last_quo;
            cnt <= cnt + 1'b1;
            // Sign fix-up is folded into the final step so END presents a finished result.
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state    <= DIV_END;
              ready_o  <= DIV_RESULT_READY;
              result_o <= {fixed_rem, fixed_quo};
            end
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP || annul_i) begin
            state    <= DIV_FREE;
            ready_o  <= DIV_RESULT_NOT_READY;
            result_o <= '0;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Randomised and directed bench for ex_div_ctrl against a plain-arithmetic
// reference for DIV/DIVU including latency, stall, annul and reset behaviour.
module tb_ex_div_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          signed_div;
  logic [W-1:0]  op1;
  logic [W-1:0]  op2;
  logic          start;
  logic          annul;
  logic [2*W-1:0] result;
  logic          ready;
  logic          stallreq;

  int check_count = 0;
  int pass_count  = 0;

  always #5 clk = ~clk;

  ex_div_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // Reference: truncating division on 64-bit integers, zero result for /0.
  function automatic logic [63:0] refDivide(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic applyStimulus(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int edges;
    int stall_cycles;
    int exp_lat;
    logic [63:0] exp_res;
    exp_res = refDivide(sgn, a, b);
    exp_lat = (b == 32'd0) ? 2 : W + 1;
    signed_div = sgn;
    op1 = a;
    op2 = b;
    annul = 1'b0;
    start = 1'b1;
    #1;
    edges = 0;
    stall_cycles = stallreq ? 1 : 0;
    while (!ready && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        op1 = $urandom;
        op2 = $urandom;
        signed_div = ~sgn;
      end
      if (stallreq) stall_cycles++;
    end
    checkOutput({tag, " latency"}, edges, exp_lat);
    checkOutput({tag, " result"}, result, exp_res);
    checkOutput({tag, " stall cycles"}, stall_cycles, exp_lat);
    @(posedge clk); #1;
    checkOutput({tag, " hold ready"}, ready, 1'b1);
    checkOutput({tag, " hold result"}, result, exp_res);
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput({tag, " drop ready"}, ready, 1'b0);
    checkOutput({tag, " drop result"}, result, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    logic [31:0] a, b;
    rst = 1'b0;
    start = 1'b0;
    annul = 1'b0;
    signed_div = 1'b0;
    op1 = '0;
    op2 = '0;
    #12;
    checkOutput("reset result", result, 64'd0);
    checkOutput("reset ready", ready, 1'b0);
    checkOutput("reset stall idle", stallreq, 1'b0);
    start = 1'b1;
    #1;
    checkOutput("reset stall follows start", stallreq, 1'b1);
    start = 1'b0;
    #1;
    rst = 1'b1;
    @(posedge clk); #1;

    applyStimulus("divu 100/7", 1'b0, 32'd100, 32'd7);
    applyStimulus("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    applyStimulus("div 5/0", 1'b1, 32'd5, 32'd0);
    applyStimulus("div overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE);

    // Annul mid-divide must abandon it without ever raising ready.
    signed_div = 1'b0;
    op1 = 32'hFFFF_FFFF;
    op2 = 32'd3;
    start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    annul = 1'b1;
    #1;
    checkOutput("annul stall", stallreq, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    annul = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready) seen = 1;
    end
    checkOutput("annul no ready", seen, 0);
    applyStimulus("divu 9/3 after annul", 1'b0, 32'd9, 32'd3);

    // Async reset mid-divide.
    op1 = 32'd1000;
    op2 = 32'd7;
    start = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst on result", result, 64'd0);
    checkOutput("rst on ready", ready, 1'b0);
    checkOutput("rst on stall", stallreq, 1'b1);
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Async reset while a result is presented.
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    seen = 0;
    while (!ready && seen < 40) begin @(posedge clk); #1; seen++; end
    checkOutput("pre-rst result", result, {32'd2, 32'd14});
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst end result", result, 64'd0);
    checkOutput("rst end ready", ready, 1'b0);
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    applyStimulus("divu 8/2 after rst", 1'b0, 32'd8, 32'd2);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = $urandom;
        default: b = 32'hFFFF_FFFF;
      endcase
      applyStimulus($sformatf("rand %0d", i), bit'($urandom_range(0, 1)), a, b);
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
